// File: rtl/fpu_pkg.sv
// Shared FPU constants and state encodings used by the conversion stages.
package fpu_pkg;

  localparam int unsigned SP_BIAS  = 127;
  localparam int unsigned SP_EXP_W = 8;
  localparam int unsigned SP_MAN_W = 23;

  typedef enum logic [2:0] {
    StWaitReq,
    StConvert,
    StNormalise,
    StRound,
    StPack,
    StOutRdy
  } i2f_state_t;

endpackage

// File: rtl/fpu_sp_rnd_ne.sv
// Combinational round-to-nearest-even of a 24-bit mantissa given guard/round/sticky bits.
module fpu_sp_rnd_ne (
  input  logic [23:0] mant,
  input  logic        guard,
  input  logic        rnd,
  input  logic        sticky,
  output logic [23:0] mant_rnd,
  output logic        carry
);

  logic        inc;
  logic [24:0] sum;

  // Exact ties go to the even neighbour via mant[0].
  assign inc      = guard & (rnd | sticky | mant[0]);
  assign sum      = {1'b0, mant} + {24'd0, inc};
  assign carry    = sum[24];
  assign mant_rnd = carry ? 24'h800000 : sum[23:0];

endmodule

// File: rtl/fpu_sp_i2f.sv
// Multi-cycle signed 32-bit integer to IEEE-754 single conversion, round-to-nearest-even.
module fpu_sp_i2f
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  input  logic        dval,
  output logic [31:0] result,
  output logic        rdy
);

  i2f_state_t            state_q, state_d;
  logic [31:0]           a_q, a_d;
  logic                  s_q, s_d;
  logic [31:0]           m_q, m_d;
  logic signed [8:0]     e_q, e_d;
  logic [SP_MAN_W-1:0]   frac_q, frac_d;
  logic [31:0]           z_q, z_d;
  logic [31:0]           result_q, result_d;
  logic                  rdy_q, rdy_d;

  logic [23:0]           mant_rnd;
  logic                  carry;
  logic [8:0]            exp_biased;
  logic                  unused_bits;

  fpu_sp_rnd_ne u_rnd (
    .mant     (m_q[31:8]),
    .guard    (m_q[7]),
    .rnd      (m_q[6]),
    .sticky   (|m_q[5:0]),
    .mant_rnd (mant_rnd),
    .carry    (carry)
  );

  assign exp_biased  = e_q + 9'(SP_BIAS);
  // Hidden bit is implied by normalisation; biased exponent never exceeds 8 bits.
  assign unused_bits = ^{exp_biased[8], mant_rnd[23]};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    s_d      = s_q;
    m_d      = m_q;
    e_d      = e_q;
    frac_d   = frac_q;
    z_d      = z_q;
    result_d = result_q;
    rdy_d    = 1'b0;
    case (state_q)
      StWaitReq: begin
        if (dval) begin
          a_d     = din;
          state_d = StConvert;
        end
      end
      StConvert: begin
        if (a_q == 32'd0) begin
          z_d     = 32'd0;
          state_d = StOutRdy;
        end else begin
          s_d     = a_q[31];
          m_d     = a_q[31] ? (~a_q + 32'd1) : a_q;
          e_d     = 9'sd31;
          state_d = StNormalise;
        end
      end
      StNormalise: begin
        if (!m_q[31]) begin
          m_d = m_q << 1;
          e_d = e_q - 9'sd1;
        end else begin
          state_d = StRound;
        end
      end
      StRound: begin
        frac_d = mant_rnd[SP_MAN_W-1:0];
        if (carry) begin
          e_d = e_q + 9'sd1;
        end
        state_d = StPack;
      end
      StPack: begin
        z_d     = {s_q, exp_biased[SP_EXP_W-1:0], frac_q};
        state_d = StOutRdy;
      end
      StOutRdy: begin
        rdy_d    = 1'b1;
        result_d = z_q;
        state_d  = StWaitReq;
      end
      default: state_d = StWaitReq;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StWaitReq;
      a_q      <= 32'd0;
      s_q      <= 1'b0;
      m_q      <= 32'd0;
      e_q      <= 9'sd0;
      frac_q   <= '0;
      z_q      <= 32'd0;
      result_q <= 32'd0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      s_q      <= s_d;
      m_q      <= m_d;
      e_q      <= e_d;
      frac_q   <= frac_d;
      z_q      <= z_d;
      result_q <= result_d;
      rdy_q    <= rdy_d;
    end
  end

  assign result = result_q;
  assign rdy    = rdy_q;

endmodule

// File: tb/tb_fpu_sp_i2f.sv
// Randomised and directed bench for fpu_sp_i2f against an arithmetic int-to-float model.
module tb_fpu_sp_i2f;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic        dval;
  logic [31:0] result;
  logic        rdy;

  int tests;
  int fails;

  // Model state: cycle count, outstanding request, last pulse cycle.
  int          cyc;
  int          due;
  int          rdy_cyc;
  bit          pending;
  logic [31:0] exp_next;
  logic [31:0] last_res;
  bit          chk_en;

  fpu_sp_i2f dut (
    .clk    (clk),
    .rst    (rst),
    .din    (din),
    .dval   (dval),
    .result (result),
    .rdy    (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] i2f(input logic [31:0] v);
    logic [63:0] mag, q, rem, half;
    int          p, sh;
    logic        s;
    if (v == 32'd0) return 32'd0;
    s   = v[31];
    mag = s ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
    p   = 0;
    for (int i = 0; i < 33; i++) if (mag[i]) p = i;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        p = p + 1;
      end
    end
    return {s, 8'(p + 127), q[22:0]};
  endfunction

  function automatic int lat(input logic [31:0] v);
    logic [32:0] mag;
    int          p;
    if (v == 32'd0) return 2;
    mag = v[31] ? (33'h1_0000_0000 - {1'b0, v}) : {1'b0, v};
    p   = 0;
    for (int i = 0; i < 33; i++) if (mag[i]) p = i;
    return (31 - p) + 5;
  endfunction

  // Model process: tracks acceptance and when each pulse is due.
  initial begin
    cyc = 0; due = 0; rdy_cyc = -1; pending = 0; exp_next = '0; last_res = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        pending  = 0;
        last_res = 32'd0;
        rdy_cyc  = -1;
      end else if (pending && cyc == due) begin
        last_res = exp_next;
        pending  = 0;
        rdy_cyc  = cyc;
      end else if (!pending && dval) begin
        due      = cyc + lat(din);
        exp_next = i2f(din);
        pending  = 1;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (chk_en) begin
        if (rst) begin
          check("rdy_in_reset", {31'd0, rdy}, 32'd0);
          check("result_in_reset", result, 32'd0);
        end else begin
          check("rdy_cycle", {31'd0, rdy}, {31'd0, (cyc == rdy_cyc)});
          check("result_cycle", result, last_res);
        end
      end
    end
  end

  // Caller must be at a negedge; request is seen by the following posedge.
  task automatic req(input logic [31:0] v);
    din  = v;
    dval = 1'b1;
    @(negedge clk);
    dval = 1'b0;
    din  = $urandom;
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (rdy) begin
        n = k;
        break;
      end
    end
  endtask

  logic [31:0] d_in  [10] = '{32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'h80000000,
                              32'h7FFFFFFF, 32'h01000001, 32'h01000003, 32'hFEFFFFFF,
                              32'h00000005, 32'h00000003};
  logic [31:0] d_exp [10] = '{32'h3F800000, 32'h00000000, 32'hBF800000, 32'hCF000000,
                              32'h4F000000, 32'h4B800000, 32'h4B800002, 32'hCB800000,
                              32'h40A00000, 32'h40400000};
  int          d_lat [10] = '{36, 2, 36, 5, 6, 12, 12, 12, 34, 35};

  initial begin
    int          n;
    logic [31:0] v;
    tests = 0; fails = 0; chk_en = 0;
    rst = 1'b1; dval = 1'b0; din = 32'd0;

    // Pin the model itself against hand-computed values.
    for (int i = 0; i < 10; i++) begin
      check("model_value", i2f(d_in[i]), d_exp[i]);
      check("model_latency", lat(d_in[i]), d_lat[i]);
    end

    @(negedge clk);
    chk_en = 1;
    repeat (3) @(negedge clk);
    check("reset_rdy", {31'd0, rdy}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      req(d_in[i]);
      wait_rdy(n);
      check("directed_latency", n, d_lat[i]);
      check("directed_result", result, d_exp[i]);
      @(negedge clk);
    end

    // A request while busy is dropped; one in the rdy cycle is taken.
    req(32'h00000010);
    repeat (2) @(negedge clk);
    din  = 32'd5;
    dval = 1'b1;
    @(negedge clk);
    dval = 1'b0;
    wait_rdy(n);
    check("busy_drop_result", result, 32'h41800000);
    req(32'h00000007);
    wait_rdy(n);
    check("b2b_latency", n, 34);
    check("b2b_result", result, 32'h40E00000);
    @(negedge clk);

    // Reset during normalisation aborts without a pulse.
    req(32'h00000001);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_rdy", {31'd0, rdy}, 32'd0);
    check("abort_result", result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    req(32'h00000003);
    wait_rdy(n);
    check("post_reset_latency", n, 35);
    check("post_reset_result", result, 32'h40400000);

    for (int i = 0; i < 150; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = -v;
      if ($urandom_range(0, 15) == 0) v = 32'd0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      req(v);
      wait_rdy(n);
      check("random_latency", n, lat(v));
      check("random_result", result, i2f(v));
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpu_sp_i2f.md
# fpu_sp_i2f

Multi-cycle converter from 32-bit two's-complement signed integer to IEEE-754 single precision, rounding to nearest, ties to even. It is the integer-to-float counterpart of the float-to-integer stage and sits beside it in the FPU execute path. It uses the same one-request, one-response `dval`/`rdy` handshake toward the RISC-V interface logic.

## Interface
Parameters:
- none; field widths and bias are fixed constants from the shared package.

Ports:
- `clk`  in  1  sole clock, all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `din`  in  32  signed integer operand, sampled when accepted.
- `dval`  in  1  request strobe; honoured only in WAIT_REQ.
- `result`  out  32  packed float; valid while `rdy`=1; holds last value otherwise.
- `rdy`  out  1  one-cycle completion pulse.

Reset values: `rdy`=0, `result`=0x00000000, state=WAIT_REQ.

## Operation
- WAIT_REQ
  - Drives `rdy`=0.
  - If `dval`=1, latches `din` into `a` and goes to CONVERT.
  - `dval` in any other state is ignored, with no queueing.
- CONVERT
  - If `a`=0: `z`=0x00000000, go to OUT_RDY.
  - Else: `s`=a[31], `m`=|a| as a 32-bit unsigned value, `e`=31 (signed 9-bit), go to NORMALISE.
  - |0x80000000| is 0x80000000 unsigned; no special case.
- NORMALISE
  - If m[31]=0: `m`<=m<<1, `e`<=e-1, stay.
  - Else go to ROUND.
  - Takes one shift cycle per leading zero L (0..31), plus one exit cycle.
- ROUND
  - Fields: mant=m[31:8], guard=m[7], rnd=m[6], sticky=|m[5:0].
  - Increment mant if guard & (rnd | sticky | mant[0]).
  - If the increment carries out of 24 bits: mant=0x800000, `e`<=e+1.
  - Go to PACK.
- PACK
  - `z`={s, (e+127)[7:0], mant[22:0]}.
  - Biased exponent range is 127..158, so no overflow, underflow or denormal is possible.
  - Go to OUT_RDY.
- OUT_RDY
  - `rdy`<=1, `result`<=z, go to WAIT_REQ.
- There is no exception or inexact flag output.

## Timing
- Acceptance edge is T0, the edge where WAIT_REQ sees `dval`=1.
- Non-zero input: `rdy`=1 is visible after edge T0+L+5 and lasts exactly one cycle.
  - L=0 gives 5 cycles.
  - L=31 (din=1) gives 36 cycles.
- Zero input: `rdy`=1 after edge T0+2.
- Back-to-back requests:
  - The cycle in which `rdy`=1 is spent in WAIT_REQ, so a `dval` presented in that cycle is accepted.
  - Minimum request spacing is therefore latency plus 0 idle cycles.
- `result` changes only on the OUT_RDY edge; it is stable between pulses.
- Reset asserted mid-operation:
  - Aborts immediately to WAIT_REQ, with `rdy`=0 and `result`=0.
  - No pulse is emitted for the aborted request.
- `din` need only be stable on the acceptance edge.

## Structure
- Shared package `fpu_pkg` holds:
  - State enum `i2f_state_t` (WAIT_REQ, CONVERT, NORMALISE, ROUND, PACK, OUT_RDY).
  - Constants SP_BIAS=127, SP_EXP_W=8, SP_MAN_W=23.
  - These are shared with the float-to-integer stage.
- Sub-module `fpu_sp_rnd_ne`: combinational round-to-nearest-even.
  - Inputs: 24-bit mantissa, guard, rnd, sticky.
  - Outputs: rounded mantissa and carry.
  - Reused later by the add/mul stages.
- Everything else is a single sequential always block.

## Test plan
- din=0x00000001 -> result=0x3F800000, `rdy` 36 cycles after acceptance.
- din=0x00000000 -> result=0x00000000, `rdy` 2 cycles after acceptance; din=0xFFFFFFFF -> 0xBF800000.
- din=0x80000000 -> 0xCF000000 in 5 cycles; din=0x7FFFFFFF -> 0x4F000000 (rounding carry bumps exponent).
- Tie-to-even cases:
  - din=0x01000001 -> 0x4B800000 (tie, rounds down).
  - din=0x01000003 -> 0x4B800002 (tie, rounds up).
  - din=0xFEFFFFFF -> 0xCB800000.
- `dval` pulsed with din=5 while busy converting 0x00000010 -> single `rdy`, result=0x41800000; the second request is dropped. A request in the `rdy` cycle is accepted.
- Assert `rst` during NORMALISE of din=1 -> `rdy` stays 0 and `result`=0. A fresh request of din=3 after release -> 0x40400000.
